mat2x2_mul_seq: RTL and testbench

//  Sequencer for a 2x2 x 2x2 fixed-point matrix multiply, C = A x B, in signed Q8.8 (Q=8, N=16).

---
 rtl/mat2x2_mul_seq.sv | 176 +++++++++++++++++
 tb/tb_mat2x2_mul_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat2x2_mul_seq.sv
// 2x2 by 2x2 signed Q8.8 matrix multiply sequencer.
// One dot-product unit is time-multiplexed over four cycles per matrix:
// each COMPUTE cycle feeds one row of A and one column of B and stores
// the resulting dot product into the matching element of C.

// Two-term signed fixed-point dot product: C = (A0*B0 + A1*B1) >>> Q,
// truncated toward minus infinity, then saturated to the N-bit range.
module mul2vector #(
  parameter int N = 16,
  parameter int Q = 8
) (
  input  logic signed [N-1:0] a0_i,
  input  logic signed [N-1:0] a1_i,
  input  logic signed [N-1:0] b0_i,
  input  logic signed [N-1:0] b1_i,
  output logic signed [N-1:0] c_o
);

  localparam logic signed [2*N:0] MAX_VAL = (2*N+1)'((1 <<< (N-1)) - 1);
  localparam logic signed [2*N:0] MIN_VAL = -(2*N+1)'(1 <<< (N-1));

  logic signed [2*N-1:0] p0;
  logic signed [2*N-1:0] p1;
  logic signed [2*N:0]   sum;
  logic signed [2*N:0]   shifted;

  // Full-precision products and sum, then scale and clamp.
  always_comb begin
    p0      = a0_i * b0_i;
    p1      = a1_i * b1_i;
    sum     = {p0[2*N-1], p0} + {p1[2*N-1], p1};
    shifted = sum >>> Q;
    if (shifted > MAX_VAL) begin
      c_o = {1'b0, {(N-1){1'b1}}};
    end else if (shifted < MIN_VAL) begin
      c_o = {1'b1, {(N-1){1'b0}}};
    end else begin
      c_o = shifted[N-1:0];
    end
  end

endmodule

module mat2x2_mul_seq #(
  parameter int N = 16,
  parameter int Q = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a00,
  input  logic [N-1:0] a01,
  input  logic [N-1:0] a10,
  input  logic [N-1:0] a11,
  input  logic [N-1:0] b00,
  input  logic [N-1:0] b01,
  input  logic [N-1:0] b10,
  input  logic [N-1:0] b11,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c00,
  output logic [N-1:0] c01,
  output logic [N-1:0] c10,
  output logic [N-1:0] c11,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t       state_q;
  logic [1:0]   idx_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;

  // Latched operands; the ports are free to change after acceptance.
  logic [N-1:0] a00_q, a01_q, a10_q, a11_q;
  logic [N-1:0] b00_q, b01_q, b10_q, b11_q;

  logic [N-1:0] c00_q, c01_q, c10_q, c11_q;

  // Dot-product unit operands and its result for the current idx.
  logic signed [N-1:0] dot_a0;
  logic signed [N-1:0] dot_a1;
  logic signed [N-1:0] dot_b0;
  logic signed [N-1:0] dot_b1;
  logic signed [N-1:0] dot_c_d;

  // idx[1] selects the row of A, idx[0] selects the column of B.
  always_comb begin
    dot_a0 = idx_q[1] ? a10_q : a00_q;
    dot_a1 = idx_q[1] ? a11_q : a01_q;
    dot_b0 = idx_q[0] ? b01_q : b00_q;
    dot_b1 = idx_q[0] ? b11_q : b10_q;
  end

  mul2vector #(
    .N(N),
    .Q(Q)
  ) u_dot (
    .a0_i(dot_a0),
    .a1_i(dot_a1),
    .b0_i(dot_b0),
    .b1_i(dot_b1),
    .c_o (dot_c_d)
  );

  // Sequencer FSM: accept, four dot products, hold result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      a00_q <= '0; a01_q <= '0; a10_q <= '0; a11_q <= '0;
      b00_q <= '0; b01_q <= '0; b10_q <= '0; b11_q <= '0;
      c00_q <= '0; c01_q <= '0; c10_q <= '0; c11_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a00_q <= a00; a01_q <= a01; a10_q <= a10; a11_q <= a11;
            b00_q <= b00; b01_q <= b01; b10_q <= b10; b11_q <= b11;
            idx_q      <= 2'd0;
            state_q    <= COMPUTE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        COMPUTE: begin
          case (idx_q)
            2'd0:    c00_q <= dot_c_d;
            2'd1:    c01_q <= dot_c_d;
            2'd2:    c10_q <= dot_c_d;
            default: c11_q <= dot_c_d;
          endcase
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          idx_q       <= 2'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign c00       = c00_q;
  assign c01       = c01_q;
  assign c10       = c10_q;
  assign c11       = c11_q;

endmodule

// File: tb/tb_mat2x2_mul_seq.sv
// Directed bench for the 2x2 matrix multiply sequencer.
module tb_mat2x2_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a00 = '0, a01 = '0, a10 = '0, a11 = '0;
  logic [15:0] b00 = '0, b01 = '0, b10 = '0, b11 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] c00, c01, c10, c11;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  mat2x2_mul_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a00      (a00),
    .a01      (a01),
    .a10      (a10),
    .a11      (a11),
    .b00      (b00),
    .b01      (b01),
    .b10      (b10),
    .b11      (b11),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c00      (c00),
    .c01      (c01),
    .c10      (c10),
    .c11      (c11),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [15:0] x00, x01, x10, x11,
                         input logic [15:0] y00, y01, y10, y11);
    a00 = x00; a01 = x01; a10 = x10; a11 = x11;
    b00 = y00; b01 = y01; b10 = y10; b11 = y11;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
               in_ready, out_valid, busy);
    end
    checks++;
    if ({c00, c01, c10, c11} !== 64'h0) begin
      errors++;
      $display("FAIL reset_c: c=%h %h %h %h, want all 0000", c00, c01, c10, c11);
    end
    $display("reset: in_ready=%b out_valid=%b busy=%b", in_ready, out_valid, busy);
  endtask

  task automatic test_identity();
    int n;
    out_ready = 1'b1;
    set_ops(16'h0100, 16'h0000, 16'h0000, 16'h0100,
            16'h0300, 16'h0080, 16'h0040, 16'h0200);
    in_valid = 1'b1;
    step();                 // accept edge
    in_valid = 1'b0;
    set_ops('0, '0, '0, '0, '0, '0, '0, '0);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ident_busy: busy=%b in_ready=%b, want 1 0", busy, in_ready);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL ident_latency: %0d edges, want 4", n);
    end
    checks++;
    if (c00 !== 16'h0300 || c01 !== 16'h0080 || c10 !== 16'h0040 || c11 !== 16'h0200) begin
      errors++;
      $display("FAIL ident_c: c=%h %h %h %h, want 0300 0080 0040 0200", c00, c01, c10, c11);
    end
    step();                 // handshake
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ident_handshake: out_valid=%b in_ready=%b busy=%b, want 0 1 0",
               out_valid, in_ready, busy);
    end
    $display("identity: latency=%0d c=%h %h %h %h", n, c00, c01, c10, c11);
  endtask

  task automatic test_mixed();
    int n;
    out_ready = 1'b1;
    set_ops(16'h0200, 16'h0100, 16'h0080, 16'h0000,
            16'h0180, 16'h0100, 16'h0100, 16'h0200);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n !== 4 || c00 !== 16'h0400 || c01 !== 16'h0400 || c10 !== 16'h00C0 || c11 !== 16'h0080) begin
      errors++;
      $display("FAIL mixed_c: lat=%0d c=%h %h %h %h, want 4 0400 0400 00c0 0080",
               n, c00, c01, c10, c11);
    end
    step();
    $display("mixed: latency=%0d c=%h %h %h %h", n, c00, c01, c10, c11);
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    set_ops(16'h0200, 16'h0100, 16'h0080, 16'h0000,
            16'h0180, 16'h0100, 16'h0100, 16'h0200);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL bp_latency: %0d edges, want 4", n);
    end
    // Identity operands pulsed in while blocked must not disturb anything.
    set_ops(16'h0100, 16'h0000, 16'h0000, 16'h0100,
            16'h0300, 16'h0080, 16'h0040, 16'h0200);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
          c00 !== 16'h0400 || c01 !== 16'h0400 || c10 !== 16'h00C0 || c11 !== 16'h0080) begin
        errors++;
        $display("FAIL bp_hold[%0d]: ov=%b ir=%b busy=%b c=%h %h %h %h, want 1 0 1 0400 0400 00c0 0080",
                 i, out_valid, in_ready, busy, c00, c01, c10, c11);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    checks++;
    if (c00 !== 16'h0400 || c01 !== 16'h0400 || c10 !== 16'h00C0 || c11 !== 16'h0080) begin
      errors++;
      $display("FAIL bp_c_after: c=%h %h %h %h, want 0400 0400 00c0 0080", c00, c01, c10, c11);
    end
    $display("backpressure: held 10 cycles, released c=%h %h %h %h", c00, c01, c10, c11);
  endtask

  task automatic test_reset_midop();
    int n;
    out_ready = 1'b1;
    set_ops(16'h0200, 16'h0100, 16'h0080, 16'h0000,
            16'h0180, 16'h0100, 16'h0100, 16'h0200);
    in_valid = 1'b1;
    step();                 // accept edge k
    in_valid = 1'b0;
    step();                 // edge k+1 writes c00
    rst = 1'b1;
    step();                 // edge k+2 resets
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        {c00, c01, c10, c11} !== 64'h0) begin
      errors++;
      $display("FAIL midrst_state: ir=%b ov=%b busy=%b c=%h %h %h %h, want 1 0 0 zeros",
               in_ready, out_valid, busy, c00, c01, c10, c11);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_no_valid[%0d]: out_valid=%b, want 0", i, out_valid);
      end
    end
    set_ops(16'h0100, 16'h0000, 16'h0000, 16'h0100,
            16'h0300, 16'h0080, 16'h0040, 16'h0200);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n !== 4 || c00 !== 16'h0300 || c01 !== 16'h0080 || c10 !== 16'h0040 || c11 !== 16'h0200) begin
      errors++;
      $display("FAIL midrst_after: lat=%0d c=%h %h %h %h, want 4 0300 0080 0040 0200",
               n, c00, c01, c10, c11);
    end
    step();
    $display("reset_midop: recovered c=%h %h %h %h", c00, c01, c10, c11);
  endtask

  task automatic test_back_to_back();
    logic [15:0] ops [3][8];
    logic [15:0] exp_c [3][4];
    int last_acc;
    int acc;
    int n;
    // m0: [[1,2],[3,4]] x [[1,0],[0,1]] = A
    ops[0] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0100, 16'h0000, 16'h0000, 16'h0100};
    exp_c[0] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    // m1: [[-1,0.5],[2,1]] x [[2,1],[4,-2]] = [[0,-2],[8,0]]
    ops[1] = '{16'hFF00, 16'h0080, 16'h0200, 16'h0100, 16'h0200, 16'h0100, 16'h0400, 16'hFE00};
    exp_c[1] = '{16'h0000, 16'hFE00, 16'h0800, 16'h0000};
    // m2: [[0.25,0.75],[1.5,-0.5]] x [[4,2],[2,4]] = [[2.5,3.5],[5,1]]
    ops[2] = '{16'h0040, 16'h00C0, 16'h0180, 16'hFF80, 16'h0400, 16'h0200, 16'h0200, 16'h0400};
    exp_c[2] = '{16'h0280, 16'h0380, 16'h0500, 16'h0100};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    last_acc  = 0;
    for (int m = 0; m < 3; m++) begin
      set_ops(ops[m][0], ops[m][1], ops[m][2], ops[m][3],
              ops[m][4], ops[m][5], ops[m][6], ops[m][7]);
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      acc = edges;
      step();               // accept edge
      set_ops('0, '0, '0, '0, '0, '0, '0, '0);
      if (m > 0) begin
        checks++;
        if (acc - last_acc !== 6) begin
          errors++;
          $display("FAIL b2b_spacing[%0d]: %0d cycles between accepts, want 6", m, acc - last_acc);
        end
      end
      last_acc = acc;
      n = 0;
      while (out_valid !== 1'b1 && n < 10) begin
        step();
        n++;
      end
      checks++;
      if (n !== 4 || c00 !== exp_c[m][0] || c01 !== exp_c[m][1] ||
          c10 !== exp_c[m][2] || c11 !== exp_c[m][3]) begin
        errors++;
        $display("FAIL b2b_c[%0d]: lat=%0d c=%h %h %h %h, want 4 %h %h %h %h", m, n,
                 c00, c01, c10, c11, exp_c[m][0], exp_c[m][1], exp_c[m][2], exp_c[m][3]);
      end
      $display("back_to_back[%0d]: accept_edge=%0d c=%h %h %h %h", m, acc, c00, c01, c10, c11);
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_mixed();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
